// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul
// Sequential unsigned shift-and-add multiplier. Each cycle the N-bit adder
// result {carry, sum} is shifted into a 2N-bit {high, low} product register,
// retiring one multiplier bit per cycle.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous, active-low reset
//   start  - request to multiply a by b (ignored while busy)
//   a      - N-bit unsigned multiplicand, captured on accept
//   b      - N-bit unsigned multiplier, captured on accept
//   busy   - high while an operation is running
//   done   - one-cycle pulse when p holds a new result
//   p      - 2N-bit product, held until the next completion
module seq_shift_add_mul #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [N-1:0]   m;
    logic [N-1:0]   h;
    logic [N-1:0]   l;
    logic [CW-1:0]  cnt;

    logic [N:0]     sum_ext;
    logic [2*N-1:0] shifted;

    // Adder stage: add the multiplicand into the high half only when the
    // current multiplier bit is set. The extra bit keeps the carry, so the
    // shifted {carry, sum, low} value never loses precision.
    always_comb begin
        sum_ext = {1'b0, h};
        if (l[0]) begin
            sum_ext = {1'b0, h} + {1'b0, m};
        end
        shifted = {sum_ext, l[N-1:1]};
    end

    // Control FSM and datapath registers. All outputs are registered here so
    // busy/done/p never depend combinationally on the inputs. The DONE state
    // may accept a new start directly, giving an N+1 cycle initiation interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            m     <= '0;
            h     <= '0;
            l     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a;
                        h     <= '0;
                        l     <= b;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    h   <= shifted[2*N-1:N];
                    l   <= shifted[N-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        p     <= shifted;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a;
                        h     <= '0;
                        l     <= b;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb_seq_shift_add_mul
// Self-checking bench for seq_shift_add_mul. Two instances share the clock and
// reset: one at N=16 for the directed scenarios, one at N=4 for an exhaustive
// operand sweep. Expected products are pushed to a per-instance queue when an
// operation is started and popped when done is seen.
module tb_seq_shift_add_mul;

    logic        clk;
    logic        rst_n;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [31:0] p16;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  p4;

    logic [31:0] q16[$];
    logic [31:0] q4[$];

    int checks;
    int errors;

    seq_shift_add_mul #(.N(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .busy  (busy16),
        .done  (done16),
        .p     (p16)
    );

    seq_shift_add_mul #(.N(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .p     (p4)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge (the accept edge) and record
    // the expected product in the scoreboard
    task automatic start_op(input bit wide, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] xe;
        logic [31:0] ye;
        if (wide) begin
            xe = {16'h0, x};
            ye = {16'h0, y};
            a16 = x;
            b16 = y;
            start16 = 1'b1;
            q16.push_back(xe * ye);
        end else begin
            xe = {28'h0, x[3:0]};
            ye = {28'h0, y[3:0]};
            a4 = x[3:0];
            b4 = y[3:0];
            start4 = 1'b1;
            q4.push_back(xe * ye);
        end
        tick();
        if (wide) start16 = 1'b0;
        else      start4  = 1'b0;
    endtask

    // Count edges until done, tracking any cycle where busy is low before
    // done or busy and done overlap. On done the expected value is popped.
    // A timeout returns cycles = -1, which never matches a real latency.
    task automatic wait_done(input bit wide, output int cycles, output int anomalies,
                             output logic [31:0] exp);
        logic d;
        logic bz;
        cycles    = 0;
        anomalies = 0;
        exp       = 'x;
        for (int k = 0; k < 200; k++) begin
            tick();
            cycles++;
            d  = wide ? done16 : done4;
            bz = wide ? busy16 : busy4;
            if (d && bz) anomalies++;
            if (d) begin
                if (wide && q16.size() > 0) exp = q16.pop_front();
                if (!wide && q4.size() > 0) exp = q4.pop_front();
                return;
            end
            if (!bz) anomalies++;
        end
        cycles = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (busy16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy16: got %b expected 0", busy16); end
        checks++; if (done16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done16: got %b expected 0", done16); end
        checks++; if (p16 !== 32'h0) begin errors++; $display("[TB] FAIL reset_p16: got %h expected 00000000", p16); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy4: got %b expected 0", busy4); end
        checks++; if (done4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done4: got %b expected 0", done4); end
        checks++; if (p4 !== 8'h0) begin errors++; $display("[TB] FAIL reset_p4: got %h expected 00", p4); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int cyc;
        int anom;
        logic [31:0] exp;
        start_op(1'b1, 16'd3, 16'd5);
        checks++; if (busy16 !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_e0: got %b expected 1", busy16); end
        wait_done(1'b1, cyc, anom, exp);
        checks++; if (cyc !== 16) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 16", cyc); end
        checks++; if (anom !== 0) begin errors++; $display("[TB] FAIL basic_handshake: got %0d anomalies expected 0", anom); end
        checks++; if (p16 !== exp) begin errors++; $display("[TB] FAIL basic_p: got %h expected %h", p16, exp); end
        checks++; if (p16 !== 32'h0000000F) begin errors++; $display("[TB] FAIL basic_p_const: got %h expected 0000000f", p16); end
        tick();
        checks++; if (done16 !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done16); end
        checks++; if (busy16 !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_busy: got %b expected 0", busy16); end
        for (int k = 0; k < 5; k++) tick();
        checks++; if (p16 !== 32'h0000000F) begin errors++; $display("[TB] FAIL basic_p_hold: got %h expected 0000000f", p16); end
    endtask

    task automatic test_extreme();
        int cyc;
        int anom;
        logic [31:0] exp;
        start_op(1'b1, 16'hFFFF, 16'hFFFF);
        wait_done(1'b1, cyc, anom, exp);
        checks++; if (cyc !== 16) begin errors++; $display("[TB] FAIL extreme_ffff_latency: got %0d expected 16", cyc); end
        checks++; if (p16 !== exp) begin errors++; $display("[TB] FAIL extreme_ffff_p: got %h expected %h", p16, exp); end
        checks++; if (p16 !== 32'hFFFE0001) begin errors++; $display("[TB] FAIL extreme_ffff_const: got %h expected fffe0001", p16); end
        tick();
        start_op(1'b1, 16'h8000, 16'h0002);
        wait_done(1'b1, cyc, anom, exp);
        checks++; if (cyc !== 16) begin errors++; $display("[TB] FAIL extreme_8000_latency: got %0d expected 16", cyc); end
        checks++; if (p16 !== exp) begin errors++; $display("[TB] FAIL extreme_8000_p: got %h expected %h", p16, exp); end
        checks++; if (anom !== 0) begin errors++; $display("[TB] FAIL extreme_handshake: got %0d anomalies expected 0", anom); end
        tick();
    endtask

    task automatic test_zero();
        int cyc;
        int anom;
        logic [31:0] exp;
        start_op(1'b1, 16'h0000, 16'h1234);
        wait_done(1'b1, cyc, anom, exp);
        checks++; if (cyc !== 16) begin errors++; $display("[TB] FAIL zero_a_latency: got %0d expected 16", cyc); end
        checks++; if (p16 !== 32'h0) begin errors++; $display("[TB] FAIL zero_a_p: got %h expected 00000000", p16); end
        tick();
        // Seed p with a nonzero value so the next zero result is observable
        start_op(1'b1, 16'h0011, 16'h0011);
        wait_done(1'b1, cyc, anom, exp);
        checks++; if (p16 !== exp) begin errors++; $display("[TB] FAIL zero_seed_p: got %h expected %h", p16, exp); end
        tick();
        start_op(1'b1, 16'h1234, 16'h0000);
        wait_done(1'b1, cyc, anom, exp);
        checks++; if (cyc !== 16) begin errors++; $display("[TB] FAIL zero_b_latency: got %0d expected 16", cyc); end
        checks++; if (p16 !== 32'h0) begin errors++; $display("[TB] FAIL zero_b_p: got %h expected 00000000", p16); end
        tick();
    endtask

    task automatic test_ignored_start();
        int cyc;
        int anom;
        int extra;
        logic [31:0] exp;
        start_op(1'b1, 16'd7, 16'd9);
        for (int k = 0; k < 4; k++) tick();
        // Sampled at E5 while RUN; must have no effect
        a16 = 16'hAAAA;
        b16 = 16'h5555;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        wait_done(1'b1, cyc, anom, exp);
        checks++; if (cyc !== 11) begin errors++; $display("[TB] FAIL ignored_latency: got %0d expected 11 after E5", cyc); end
        checks++; if (p16 !== 32'd63) begin errors++; $display("[TB] FAIL ignored_p: got %h expected 0000003f", p16); end
        checks++; if (p16 !== exp) begin errors++; $display("[TB] FAIL ignored_sb: got %h expected %h", p16, exp); end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done16 || busy16) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL ignored_extra_activity: got %0d cycles expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int anom;
        logic [31:0] exp;
        a16 = 16'd2;
        b16 = 16'd3;
        start16 = 1'b1;
        q16.push_back(32'd6);
        tick();
        wait_done(1'b1, cyc, anom, exp);
        checks++; if (cyc !== 16) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected 16", cyc); end
        checks++; if (p16 !== exp) begin errors++; $display("[TB] FAIL b2b_first_p: got %h expected %h", p16, exp); end
        a16 = 16'd4;
        b16 = 16'd5;
        q16.push_back(32'd20);
        tick();
        checks++; if (busy16 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_no_idle_busy: got %b expected 1", busy16); end
        checks++; if (done16 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_idle_done: got %b expected 0", done16); end
        start16 = 1'b0;
        wait_done(1'b1, cyc, anom, exp);
        checks++; if (cyc !== 16) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected 16", cyc); end
        checks++; if (p16 !== exp) begin errors++; $display("[TB] FAIL b2b_second_p: got %h expected %h", p16, exp); end
        checks++; if (p16 !== 32'd20) begin errors++; $display("[TB] FAIL b2b_second_const: got %h expected 00000014", p16); end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int anom;
        int extra;
        logic [31:0] exp;
        a16 = 16'd11;
        b16 = 16'd13;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (busy16 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy16); end
        checks++; if (done16 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", done16); end
        checks++; if (p16 !== 32'h0) begin errors++; $display("[TB] FAIL midrst_p: got %h expected 00000000", p16); end
        tick();
        tick();
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done16 || busy16) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d cycles expected 0", extra); end
        checks++; if (p16 !== 32'h0) begin errors++; $display("[TB] FAIL midrst_p_after: got %h expected 00000000", p16); end
        start_op(1'b1, 16'd5, 16'd5);
        wait_done(1'b1, cyc, anom, exp);
        checks++; if (cyc !== 16) begin errors++; $display("[TB] FAIL midrst_new_latency: got %0d expected 16", cyc); end
        checks++; if (p16 !== 32'd25) begin errors++; $display("[TB] FAIL midrst_new_p: got %h expected 00000019", p16); end
        checks++; if (p16 !== exp) begin errors++; $display("[TB] FAIL midrst_new_sb: got %h expected %h", p16, exp); end
        tick();
    endtask

    task automatic test_exhaustive_n4();
        int cyc;
        int anom;
        logic [31:0] exp;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                start_op(1'b0, 16'(x), 16'(y));
                wait_done(1'b0, cyc, anom, exp);
                checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL n4_latency %0d*%0d: got %0d expected 4", x, y, cyc); end
                checks++; if ({24'h0, p4} !== exp) begin errors++; $display("[TB] FAIL n4_p %0d*%0d: got %h expected %h", x, y, p4, exp); end
                checks++; if (anom !== 0) begin errors++; $display("[TB] FAIL n4_handshake %0d*%0d: got %0d anomalies expected 0", x, y, anom); end
                tick();
            end
        end
        checks++; if (p4 !== 8'hE1) begin errors++; $display("[TB] FAIL n4_15x15: got %h expected e1", p4); end
    endtask

    // Main sequence
    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start16 = 1'b0;
        a16     = '0;
        b16     = '0;
        start4  = 1'b0;
        a4      = '0;
        b4      = '0;
        #1;
        test_reset();
        test_basic();
        test_extreme();
        test_zero();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive_n4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
